// File: rtl/ifetch_rx.sv
// Fetch-receive queue between instruction fetch and decode.
// Pairs each accepted fetch address with the word the synchronous memory returns one
// cycle later, buffers the pairs in a small FIFO, and drives fetch stall/branch.
module ifetch_rx #(
  parameter int unsigned ADDR  = 16,
  parameter int unsigned INST  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [ADDR-1:0] addr_i,
  input  logic [INST-1:0] inst_i,
  output logic            stall_o,
  output logic            branch_o,
  output logic [ADDR-1:0] baddr_o,
  input  logic            redir_i,
  input  logic [ADDR-1:0] redir_addr_i,
  output logic            out_v_o,
  output logic [INST-1:0] out_inst_o,
  output logic [ADDR-1:0] out_pc_o,
  input  logic            out_rdy_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  logic [ADDR-1:0] pc_mem_q   [DEPTH];
  logic [INST-1:0] inst_mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pend_q, pend_d;
  logic [ADDR-1:0] pend_pc_q, pend_pc_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic [CntW:0]   occupancy;

  // Combinational control: stall looks only at registers and redir_i so a same-cycle
  // pop never releases it; redirect suppresses the in-flight push and any pop.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, pend_q};
    stall_o    = ~redir_i & (occupancy >= DepthC);
    branch_o   = redir_i;
    baddr_o    = redir_addr_i;
    out_v_o    = (count_q != '0);
    out_pc_o   = pc_mem_q[rd_ptr_q];
    out_inst_o = inst_mem_q[rd_ptr_q];
    accept     = v_i & ~stall_o & ~redir_i;
    push       = pend_q & ~redir_i;
    pop        = out_v_o & out_rdy_i & ~redir_i;
  end

  // Next-state for pointers, occupancy count and the in-flight fetch tracker.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pend_d    = accept;
    pend_pc_d = accept ? addr_i : pend_pc_q;
    if (redir_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // FIFO storage: pairs the pending PC with the memory word returned this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= pend_pc_q;
      inst_mem_q[wr_ptr_q] <= inst_i;
    end
  end

endmodule

// File: tb/tb_ifetch_rx.sv
// Self-checking bench for ifetch_rx: directed scenarios plus random traffic, compared
// each cycle against a queue-based model of the receive buffer.
module tb_ifetch_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [31:0] inst_i = '0;
  logic        stall_o;
  logic        branch_o;
  logic [15:0] baddr_o;
  logic        redir_i = 1'b0;
  logic [15:0] redir_addr_i = '0;
  logic        out_v_o;
  logic [31:0] out_inst_o;
  logic [15:0] out_pc_o;
  logic        out_rdy_i = 1'b0;

  ifetch_rx #(.ADDR(16), .INST(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .v_i          (v_i),
    .addr_i       (addr_i),
    .inst_i       (inst_i),
    .stall_o      (stall_o),
    .branch_o     (branch_o),
    .baddr_o      (baddr_o),
    .redir_i      (redir_i),
    .redir_addr_i (redir_addr_i),
    .out_v_o      (out_v_o),
    .out_inst_o   (out_inst_o),
    .out_pc_o     (out_pc_o),
    .out_rdy_i    (out_rdy_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {pc, inst} pairs plus the outstanding fetch.
  logic [47:0] mq[$];
  bit          m_pend = 0;
  logic [15:0] m_pend_pc = '0;
  logic [15:0] fpc = '0;       // fetch stage PC
  logic [15:0] prev_addr = '0; // address presented to memory last cycle

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input bit rdy, input bit redir, input logic [15:0] raddr);
    bit          m_stall;
    bit          acc;
    int          sz;
    logic [47:0] head;
    v_i          = v;
    out_rdy_i    = rdy;
    redir_i      = redir;
    redir_addr_i = raddr;
    addr_i       = fpc;
    inst_i       = mem_word(prev_addr);
    #1;
    m_stall = !redir && ((mq.size() + int'(m_pend)) >= DEPTH);
    check("stall", 64'(stall_o), 64'(m_stall));
    check("branch", 64'(branch_o), 64'(redir));
    check("baddr", 64'(baddr_o), 64'(raddr));
    check("out_v", 64'(out_v_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      head = mq[0];
      check("out_pc", 64'(out_pc_o), 64'(head[47:32]));
      check("out_inst", 64'(out_inst_o), 64'(head[31:0]));
    end
    acc = v && !m_stall && !redir;
    if (redir) begin
      mq.delete();
    end else begin
      sz = mq.size();
      if (sz != 0 && rdy) void'(mq.pop_front());
      if (m_pend) begin
        if (sz >= DEPTH) check("push_at_full", 64'(sz), 64'(DEPTH - 1));
        mq.push_back({m_pend_pc, inst_i});
      end
    end
    m_pend    = acc;
    m_pend_pc = fpc;
    prev_addr = fpc;
    if (redir) fpc = raddr;
    else if (v && !m_stall) fpc = fpc + 16'd1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);
  endtask

  initial begin
    // Reset: outputs idle while branch/baddr still pass through.
    rst          = 1'b0;
    redir_i      = 1'b1;
    redir_addr_i = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_v", 64'(out_v_o), 64'(0));
      check("rst_stall", 64'(stall_o), 64'(0));
      check("rst_branch", 64'(branch_o), 64'(1));
      check("rst_baddr", 64'(baddr_o), 64'h1234);
    end
    redir_i = 1'b0;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0);

    // Streaming 0..7 with downstream always ready.
    fpc = 16'h0000;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 16'h0);
    drain();

    // Backpressure: fill to DEPTH, release one slot, refill.
    fpc = 16'h0100;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0);

    // Redirect while full, then stream from the new target.
    step(1, 0, 1, 16'h0040);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 16'h0);
    drain();

    // Redirect with 3 queued plus one in flight; in-flight word must vanish.
    fpc = 16'h0200;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0);
    step(1, 1, 1, 16'h0040);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h0);
    drain();

    // Fill to 3 then sustained push/pop with varying ready across pointer wrap.
    fpc = 16'h0300;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0);
    for (int i = 0; i < 20; i++) step(1, ($urandom_range(0, 3) != 0), 0, 16'h0);
    drain();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), 16'($urandom));
    end

    // Asynchronous reset mid-operation with traffic in the queue.
    fpc = 16'h0500;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_v", 64'(out_v_o), 64'(0));
    check("arst_stall", 64'(stall_o), 64'(0));
    mq.delete();
    m_pend = 0;
    @(negedge clk);
    check("arst_hold_out_v", 64'(out_v_o), 64'(0));
    prev_addr = fpc;
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 29) == 0), 16'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
